// File: rtl/alu_addsub_if.sv
// Handshake and adder-side bundle for the add/subtract staging block.
// The slave modport is the stage itself; master is the environment (upstream, adder, downstream).
interface alu_addsub_if #(
  parameter int WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_op;
  logic signed [WIDTH-1:0] in_a;
  logic signed [WIDTH-1:0] in_b;
  logic signed [WIDTH-1:0] add_a;
  logic signed [WIDTH-1:0] add_b;
  logic                    add_cin;
  logic signed [WIDTH-1:0] add_sum;
  logic                    add_cout;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_result;
  logic [3:0]              out_flags;
  logic                    carry_flag;

  modport slave (
    input  in_valid, in_op, in_a, in_b, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_result, out_flags, carry_flag
  );

  modport master (
    output in_valid, in_op, in_a, in_b, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_result, out_flags, carry_flag
  );
endinterface

// File: rtl/alu_addsub_stage.sv
// Operand staging and result capture around the external 8-bit CLA adder.
// Conditions ADD/SUB/ADC/SBC operands, captures sum/carry, and produces {N,Z,C,V}.
module alu_addsub_stage #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  alu_addsub_if.slave bus
);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] add_a_q, add_a_d;
  logic signed [WIDTH-1:0] add_b_q, add_b_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic                    add_cin_q, add_cin_d;
  logic                    carry_q, carry_d;
  logic [3:0]              flags_q, flags_d;
  logic                    in_ready;
  logic                    out_valid;
  logic                    xfer;

  // V uses the effective (possibly inverted) B, so subtraction overflow falls out of the add rule.
  function automatic logic [3:0] calc_flags(
    input logic signed [WIDTH-1:0] sum,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic                    cout
  );
    logic n, z, v;
    n = sum[WIDTH-1];
    z = (sum == '0);
    v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    return {n, z, cout, v};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (xfer) state_d = CALC;
      CALC:    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = bus.in_valid ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    out_valid = (state_q == DONE);
    xfer      = bus.in_valid && in_ready;
  end

  always_comb begin
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
    result_d  = result_q;
    flags_d   = flags_q;
    carry_d   = carry_q;
    if (xfer) begin
      add_a_d = bus.in_a;
      unique case (bus.in_op)
        OP_ADD: begin add_b_d = bus.in_b;  add_cin_d = 1'b0;    end
        OP_SUB: begin add_b_d = ~bus.in_b; add_cin_d = 1'b1;    end
        OP_ADC: begin add_b_d = bus.in_b;  add_cin_d = carry_q; end
        OP_SBC: begin add_b_d = ~bus.in_b; add_cin_d = carry_q; end
        default: ;
      endcase
    end
    // Adder has had a full cycle to settle from the registered operands.
    if (state_q == CALC) begin
      result_d = bus.add_sum;
      flags_d  = calc_flags(bus.add_sum, add_a_q, add_b_q, bus.add_cout);
      carry_d  = bus.add_cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      carry_q   <= 1'b0;
    end else begin
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      carry_q   <= carry_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.add_cin    = add_cin_q;
  assign bus.out_result = result_q;
  assign bus.out_flags  = flags_q;
  assign bus.carry_flag = carry_q;
endmodule

// File: tb/tb_alu_addsub_stage.sv
// Directed plus randomized bench for alu_addsub_stage with an arithmetic reference model.
module tb_alu_addsub_stage;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic mc;

  logic [7:0] e_res, e_b;
  logic [3:0] e_flags;
  logic       e_cin, e_c;

  alu_addsub_if #(.WIDTH(8)) bif ();

  alu_addsub_stage #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // External adder
  logic [8:0] adder_full;
  assign adder_full   = {1'b0, $unsigned(bif.add_a)} + {1'b0, $unsigned(bif.add_b)} + {8'd0, bif.add_cin};
  assign bif.add_sum  = adder_full[7:0];
  assign bif.add_cout = adder_full[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: unsigned result decides carry/borrow, signed result decides overflow.
  task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic cflag);
    int ua, ub, sa, sb, ci, u, s;
    logic is_sub;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    is_sub = op[0];
    ci = (op[1]) ? int'(cflag) : (is_sub ? 1 : 0);
    if (is_sub) begin
      u = ua - ub - (1 - ci);
      s = sa - sb - (1 - ci);
      e_c = (u >= 0);
      e_b = ~b;
    end else begin
      u = ua + ub + ci;
      s = sa + sb + ci;
      e_c = (u > 255);
      e_b = b;
    end
    e_cin = ci[0];
    e_res = u[7:0];
    e_flags = {e_res[7], (e_res == 8'h00), e_c, ((s < -128) || (s > 127))};
  endtask

  // Called at a negedge with out_ready=1; returns at the negedge where the result is shown.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    model(op, a, b, mc);
    mc = e_c;
    bif.in_valid = 1'b1;
    bif.in_op = op;
    bif.in_a = a;
    bif.in_b = b;
    #1;
    check("in_ready_at_xfer", 16'(bif.in_ready), 16'h1);
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    bif.in_a = $urandom;
    bif.in_b = $urandom;
    bif.in_op = 2'($urandom);
    check("add_a", 16'($unsigned(bif.add_a)), 16'(a));
    check("add_b", 16'($unsigned(bif.add_b)), 16'(e_b));
    check("add_cin", 16'(bif.add_cin), 16'(e_cin));
    check("out_valid_calc", 16'(bif.out_valid), 16'h0);
    @(posedge clk);
    @(negedge clk);
    check("out_valid_done", 16'(bif.out_valid), 16'h1);
    check("out_result", 16'($unsigned(bif.out_result)), 16'(e_res));
    check("out_flags", 16'(bif.out_flags), 16'(e_flags));
    check("carry_flag", 16'(bif.carry_flag), 16'(e_c));
  endtask

  task automatic idle_cycle();
    bif.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("out_valid_idle", 16'(bif.out_valid), 16'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mc = 1'b0;
    rst = 1'b1;
    bif.in_valid = 1'b1;
    bif.in_op = 2'b00;
    bif.in_a = 8'h11;
    bif.in_b = 8'h22;
    bif.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 16'(bif.in_ready), 16'h0);
    check("rst_out_valid", 16'(bif.out_valid), 16'h0);
    check("rst_out_result", 16'($unsigned(bif.out_result)), 16'h0);
    check("rst_out_flags", 16'(bif.out_flags), 16'h0);
    check("rst_carry", 16'(bif.carry_flag), 16'h0);
    check("rst_add_a", 16'($unsigned(bif.add_a)), 16'h0);
    check("rst_add_b", 16'($unsigned(bif.add_b)), 16'h0);
    check("rst_add_cin", 16'(bif.add_cin), 16'h0);
    bif.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 16'(bif.in_ready), 16'h1);
    @(negedge clk);

    // ADD overflow into sign bit
    do_op(2'b00, 8'h7F, 8'h01);
    check("add7f_res", 16'($unsigned(bif.out_result)), 16'h80);
    check("add7f_flags", 16'(bif.out_flags), 16'b1001);
    idle_cycle();

    // SUB equal operands
    do_op(2'b01, 8'h05, 8'h05);
    check("sub55_addb", 16'($unsigned(bif.add_b)), 16'hFA);
    check("sub55_flags", 16'(bif.out_flags), 16'b0110);
    idle_cycle();

    // 16-bit chain, second byte issued straight from DONE
    do_op(2'b00, 8'hFF, 8'h01);
    check("chain_lo_flags", 16'(bif.out_flags), 16'b0110);
    do_op(2'b10, 8'h00, 8'h00);
    check("chain_hi_res", 16'($unsigned(bif.out_result)), 16'h01);
    check("chain_hi_carry", 16'(bif.carry_flag), 16'h0);
    idle_cycle();

    // Signed overflow on subtraction, then SBC with carry set
    do_op(2'b01, 8'h80, 8'h01);
    check("sub80_flags", 16'(bif.out_flags), 16'b0011);
    do_op(2'b11, 8'h00, 8'h00);
    check("sbc00_flags", 16'(bif.out_flags), 16'b0110);
    idle_cycle();

    // Backpressure with a request waiting
    do_op(2'b00, 8'h7F, 8'h01);
    bif.out_ready = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_op = 2'b00;
    bif.in_a = 8'h01;
    bif.in_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 16'(bif.in_ready), 16'h0);
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 16'(bif.out_valid), 16'h1);
      check("bp_out_result", 16'($unsigned(bif.out_result)), 16'h80);
      check("bp_out_flags", 16'(bif.out_flags), 16'b1001);
      check("bp_add_a", 16'($unsigned(bif.add_a)), 16'h7F);
    end
    bif.out_ready = 1'b1;
    do_op(2'b00, 8'h01, 8'h01);
    check("bp_after_res", 16'($unsigned(bif.out_result)), 16'h02);

    // Reset in the middle of CALC, with carry set beforehand
    do_op(2'b00, 8'hFF, 8'h01);
    bif.in_valid = 1'b1;
    bif.in_op = 2'b00;
    bif.in_a = 8'h10;
    bif.in_b = 8'h20;
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 16'(bif.out_valid), 16'h0);
    check("midrst_result", 16'($unsigned(bif.out_result)), 16'h0);
    check("midrst_carry", 16'(bif.carry_flag), 16'h0);
    check("midrst_in_ready", 16'(bif.in_ready), 16'h0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_hold_valid", 16'(bif.out_valid), 16'h0);
    rst = 1'b0;
    mc = 1'b0;
    #1;
    check("midrst_release_ready", 16'(bif.in_ready), 16'h1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_result_valid", 16'(bif.out_valid), 16'h0);
      check("midrst_no_result", 16'($unsigned(bif.out_result)), 16'h0);
    end

    // Randomized operations with random idle gaps
    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
      do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
